mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline, directly downstream of the execute stage.
- Consumes the 154-bit EXE->MEM bus.
- Performs loads and stores through a variable-latency request/acknowledge data-cache port, with byte steering and sign/zero extension.
- Produces the 118-bit MEM->WB bus, the MEM destination register for hazard detection, the bypass result, and the stage PC for display.

Parameters:
- none; bus widths are fixed by the pipeline bus definitions.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MEM_valid  in  1  MEM stage holds a valid instruction
- EXE_MEM_bus_r  in  154  registered EXE->MEM bus, MSB first: mem_control[3:0]={inst_load,inst_store,ls_word,lb_sign}, store_data[31:0], exe_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, rf_wen, rf_wdest[4:0], pc[31:0]
- MEM_accept  in  1  WB latches MEM_WB_bus this cycle (MEM_over & WB allow-in)
- MEM_over  out  1  MEM work complete; bus valid for WB
- MEM_WB_bus  out  118  MSB first: mem_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, rf_wen, rf_wdest[4:0], pc[31:0]
- dc_req  out  1  data-cache request
- dc_wr  out  1  1=store, 0=load
- dc_addr  out  32  word address {exe_result[31:2],2'b00}
- dc_wstrb  out  4  store byte enables
- dc_wdata  out  32  store data
- dc_ack  in  1  cache completes the request this cycle
- dc_rdata  in  32  load word; valid when dc_ack=1
- MEM_wdest  out  5  rf_wdest & {5{MEM_valid}}
- MEM_result  out  32  bypass value: inst_load ? load_data : exe_result
- MEM_load_pending  out  1  MEM_valid & inst_load & ~MEM_over
- MEM_pc  out  32  pc field

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset forces IDLE, dc_req=0, load_data register=0. Reset mid-request abandons the request; the cache must tolerate a request dropping without ack.
- mem_op = inst_load | inst_store.
- IDLE:
  - MEM_valid & mem_op -> REQ next cycle; MEM_over=0.
  - MEM_valid & ~mem_op: MEM_over=MEM_valid combinationally; state stays IDLE; MEM_accept ignored.
- REQ:
  - dc_req=1; dc_wr, dc_addr, dc_wstrb and dc_wdata are held stable until dc_ack.
  - dc_ack=1 -> latch extended load data (loads only) -> DONE. The ack may arrive in the first REQ cycle.
- DONE:
  - MEM_over=1.
  - MEM_accept -> IDLE; otherwise hold DONE and keep data stable indefinitely (WB stall).
- Minimum memory-op latency: MEM_over asserts 2 cycles after MEM_valid first rises, with zero-wait ack.
- MEM_valid and the bus stay constant while in REQ/DONE; the pipeline guarantees this. Behaviour is undefined if they change.
- dc_req=0 in IDLE and DONE. There is never a second request for the same instruction.
- Stores:
  - ls_word: dc_wstrb=4'b1111, dc_wdata=store_data.
  - byte: dc_wstrb=4'b0001<<exe_result[1:0], dc_wdata={4{store_data[7:0]}}.
  - mem_result=exe_result.
- Loads:
  - ls_word: load_data=dc_rdata.
  - byte: b=dc_rdata[8*addr[1:0]+:8]; load_data = lb_sign ? {{24{b[7]}},b} : {24'b0,b}.
- Unaligned word addresses: low bits are ignored; no exception.
- Non-load: mem_result=exe_result. All other WB fields pass through unchanged.
- MEM_result before a load completes is don't-care; consumers must check MEM_load_pending.

Test Plan:
- ALU op, MEM_valid=1, exe_result=0x12345678, rf_wdest=5 -> MEM_over=1 same cycle, dc_req never 1, MEM_WB_bus mem_result=0x12345678, MEM_wdest=5.
- lw addr 0x100, dc_ack 3 cycles after dc_req -> dc_req high exactly 3 cycles with dc_addr=0x100; MEM_over the cycle after ack; mem_result=dc_rdata=0xDEADBEEF.
- lb addr 0x103 signed, dc_rdata=0x80112233 -> mem_result=0xFFFFFF80; lbu same -> 0x00000080; lb addr 0x101 -> 0x00000022.
- sb addr 0x202, store_data=0x000000A5, zero-wait ack -> dc_wr=1, dc_wstrb=4'b0100, dc_wdata=0xA5A5A5A5; sw -> wstrb=4'b1111.
- Load in DONE, MEM_accept=0 for 4 cycles -> MEM_over and mem_result stable. Then accept -> IDLE; next lw issues a fresh dc_req.
- Reset asserted in REQ -> next cycle dc_req=0, MEM_over=0, state IDLE; a later load completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle for the memory stage: EXE->MEM input bus, MEM->WB output bus,
// data-cache request/ack port and the hazard/bypass taps.
interface mem_stage_if;
  logic         MEM_valid;
  logic [153:0] EXE_MEM_bus_r;
  logic         MEM_accept;
  logic         MEM_over;
  logic [117:0] MEM_WB_bus;
  logic         dc_req;
  logic         dc_wr;
  logic [31:0]  dc_addr;
  logic [3:0]   dc_wstrb;
  logic [31:0]  dc_wdata;
  logic         dc_ack;
  logic [31:0]  dc_rdata;
  logic [4:0]   MEM_wdest;
  logic [31:0]  MEM_result;
  logic         MEM_load_pending;
  logic [31:0]  MEM_pc;

  // master: pipeline + cache side driving the stage
  modport master (
    output MEM_valid, EXE_MEM_bus_r, MEM_accept, dc_ack, dc_rdata,
    input  MEM_over, MEM_WB_bus, dc_req, dc_wr, dc_addr, dc_wstrb, dc_wdata,
           MEM_wdest, MEM_result, MEM_load_pending, MEM_pc
  );

  modport slave (
    input  MEM_valid, EXE_MEM_bus_r, MEM_accept, dc_ack, dc_rdata,
    output MEM_over, MEM_WB_bus, dc_req, dc_wr, dc_addr, dc_wstrb, dc_wdata,
           MEM_wdest, MEM_result, MEM_load_pending, MEM_pc
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one cache request per load/store,
// steers/extends load bytes and forwards the remaining EXE fields to WB.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  mif
);

  typedef struct packed {
    logic        inst_load;
    logic        inst_store;
    logic        ls_word;
    logic        lb_sign;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [85:0] wb_pass;   // lo_result .. pc, forwarded untouched
  } exe_bus_t;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  exe_bus_t    eb;
  state_t      state_q, state_d;
  logic [31:0] load_data_q, load_data_d;
  logic [7:0]  ld_byte;
  logic [31:0] ld_ext;
  logic        mem_op;
  logic        mem_over;
  logic [31:0] mem_result;

  assign eb     = exe_bus_t'(mif.EXE_MEM_bus_r);
  assign mem_op = eb.inst_load | eb.inst_store;

  always_comb begin
    case (eb.exe_result[1:0])
      2'd0:    ld_byte = mif.dc_rdata[7:0];
      2'd1:    ld_byte = mif.dc_rdata[15:8];
      2'd2:    ld_byte = mif.dc_rdata[23:16];
      default: ld_byte = mif.dc_rdata[31:24];
    endcase
    ld_ext = eb.ls_word ? mif.dc_rdata : {{24{eb.lb_sign & ld_byte[7]}}, ld_byte};
  end

  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    mem_over    = 1'b0;
    case (state_q)
      IDLE: begin
        // non-memory ops finish combinationally without leaving IDLE
        mem_over = mif.MEM_valid & ~mem_op;
        if (mif.MEM_valid & mem_op) state_d = REQ;
      end
      REQ: begin
        if (mif.dc_ack) begin
          state_d = DONE;
          if (eb.inst_load) load_data_d = ld_ext;
        end
      end
      DONE: begin
        mem_over = 1'b1;
        if (mif.MEM_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  // request fields come straight from the bus, which is frozen while in REQ
  assign mif.dc_req   = (state_q == REQ);
  assign mif.dc_wr    = eb.inst_store;
  assign mif.dc_addr  = {eb.exe_result[31:2], 2'b00};
  assign mif.dc_wstrb = eb.ls_word ? 4'b1111 : (4'b0001 << eb.exe_result[1:0]);
  assign mif.dc_wdata = eb.ls_word ? eb.store_data : {4{eb.store_data[7:0]}};

  assign mem_result           = eb.inst_load ? load_data_q : eb.exe_result;
  assign mif.MEM_over         = mem_over;
  assign mif.MEM_WB_bus       = {mem_result, eb.wb_pass};
  assign mif.MEM_result       = mem_result;
  assign mif.MEM_wdest        = eb.wb_pass[36:32] & {5{mif.MEM_valid}};
  assign mif.MEM_load_pending = mif.MEM_valid & eb.inst_load & ~mem_over;
  assign mif.MEM_pc           = eb.wb_pass[31:0];

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops scored against
// an arithmetic model of load/store results and handshake timing.
module tb_mem_stage;
  logic clk;
  logic reset;
  mem_stage_if mif();

  mem_stage dut (.clk(clk), .reset(reset), .mif(mif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          over_cyc;
    int          reqs;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [117:0] wb;
    logic [31:0] res;
    logic [4:0]  wdest;
    logic [31:0] pc;
    bit          stable;
    bit          pend_ok;
    bit          idle_after;
  } obs_t;

  // ctrl = {inst_load, inst_store, ls_word, lb_sign}; other WB fields random
  function automatic logic [153:0] mk_bus(input logic [3:0] ctrl, input logic [31:0] sd,
                                          input logic [31:0] er, input logic [4:0] wd,
                                          input logic [31:0] pc);
    logic [31:0] lo;
    logic [5:0]  fl;
    logic [7:0]  cp;
    logic [2:0]  ex;
    lo = $urandom; fl = 6'($urandom); cp = 8'($urandom); ex = 3'($urandom);
    return {ctrl, sd, er, lo, fl, cp, ex, wd, pc};
  endfunction

  function automatic logic [31:0] exp_res(input logic [153:0] b, input logic [31:0] rdata);
    logic [31:0] a, byt;
    a = b[117:86];
    if (!b[153]) return a;
    if (b[151]) return rdata;
    byt = (rdata >> (8 * (a % 4))) & 32'hFF;
    if (b[150] && byt >= 128) byt = byt + 32'hFFFFFF00;
    return byt;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [153:0] b);
    logic [31:0] a;
    a = b[117:86];
    if (b[151]) return 4'hF;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [153:0] b);
    logic [31:0] sd;
    sd = b[149:118];
    if (b[151]) return sd;
    return (sd & 32'hFF) * 32'h01010101;
  endfunction

  // Drive one instruction, act as cache (ack on wait_n-th request cycle),
  // stall WB for hold cycles, then accept and record what was seen.
  task automatic run_op(input logic [153:0] b, input int wait_n, input logic [31:0] rdata,
                        input int hold, output obs_t o);
    int cyc, reqs;
    bit done;
    o.over_cyc = -1; o.reqs = 0; o.wr = 'x; o.addr = 'x; o.wstrb = 'x; o.wdata = 'x;
    o.wb = 'x; o.res = 'x; o.wdest = 'x; o.pc = 'x;
    o.stable = 1; o.pend_ok = 1; o.idle_after = 0;
    @(negedge clk);
    mif.EXE_MEM_bus_r = b; mif.MEM_valid = 1'b1; mif.dc_ack = 1'b0; mif.MEM_accept = 1'b0;
    reqs = 0; cyc = 0; done = 0;
    while (!done && cyc < 64) begin
      #1;
      if (mif.MEM_over === 1'b1) begin
        done = 1; o.over_cyc = cyc;
        o.wb = mif.MEM_WB_bus; o.res = mif.MEM_result; o.wdest = mif.MEM_wdest; o.pc = mif.MEM_pc;
        if (mif.MEM_load_pending !== 1'b0) o.pend_ok = 0;
        if (mif.dc_req !== 1'b0) o.stable = 0;
      end else begin
        if (mif.MEM_load_pending !== b[153]) o.pend_ok = 0;
        if (mif.dc_req === 1'b1) begin
          reqs++;
          if (reqs == 1) begin
            o.wr = mif.dc_wr; o.addr = mif.dc_addr; o.wstrb = mif.dc_wstrb; o.wdata = mif.dc_wdata;
          end else if (mif.dc_wr !== o.wr || mif.dc_addr !== o.addr ||
                       mif.dc_wstrb !== o.wstrb || mif.dc_wdata !== o.wdata) o.stable = 0;
          if (reqs == wait_n) begin mif.dc_ack = 1'b1; mif.dc_rdata = rdata; end
        end
        @(negedge clk);
        mif.dc_ack = 1'b0; mif.dc_rdata = $urandom;
        cyc++;
      end
    end
    o.reqs = reqs;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (mif.MEM_over !== 1'b1 || mif.MEM_WB_bus !== o.wb || mif.MEM_result !== o.res ||
          mif.dc_req !== 1'b0) o.stable = 0;
    end
    mif.MEM_accept = 1'b1;
    @(negedge clk);
    mif.MEM_accept = 1'b0; mif.MEM_valid = 1'b0;
    #1;
    o.idle_after = (mif.MEM_over === 1'b0 && mif.dc_req === 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mif.MEM_valid = 1'b0; mif.MEM_accept = 1'b0; mif.dc_ack = 1'b0; mif.dc_rdata = '0;
    mif.EXE_MEM_bus_r = mk_bus(4'b1010, 32'h0, 32'h40, 5'd9, 32'hBFC0_0000);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mif.dc_req !== 1'b0) begin errors++; $display("FAIL reset_dc_req got=%b exp=0", mif.dc_req); end
    checks++; if (mif.MEM_over !== 1'b0) begin errors++; $display("FAIL reset_over got=%b exp=0", mif.MEM_over); end
    checks++; if (mif.MEM_result !== 32'h0) begin errors++; $display("FAIL reset_load_data got=%h exp=0", mif.MEM_result); end
    checks++; if (mif.MEM_wdest !== 5'd0) begin errors++; $display("FAIL reset_wdest got=%0d exp=0", mif.MEM_wdest); end
    reset = 1'b0;
  endtask

  task automatic test_alu;
    obs_t o;
    logic [153:0] b;
    b = mk_bus(4'b0000, 32'hCAFE, 32'h12345678, 5'd5, 32'h0040_0010);
    @(negedge clk);
    mif.EXE_MEM_bus_r = b; mif.MEM_valid = 1'b1; #1;
    checks++; if (mif.MEM_wdest !== 5'd5) begin errors++; $display("FAIL alu_wdest got=%0d exp=5", mif.MEM_wdest); end
    mif.MEM_valid = 1'b0;
    run_op(b, 1, 32'h0, 2, o);
    checks++; if (o.over_cyc !== 0) begin errors++; $display("FAIL alu_over_cycle got=%0d exp=0", o.over_cyc); end
    checks++; if (o.reqs !== 0 || !o.stable) begin errors++; $display("FAIL alu_no_req reqs=%0d stable=%0d exp 0/1", o.reqs, o.stable); end
    checks++; if (o.wb !== {32'h12345678, b[85:0]}) begin errors++; $display("FAIL alu_wb_bus got=%h exp=%h", o.wb, {32'h12345678, b[85:0]}); end
    checks++; if (o.pc !== 32'h0040_0010) begin errors++; $display("FAIL alu_pc got=%h exp=00400010", o.pc); end
    checks++; if (!o.idle_after) begin errors++; $display("FAIL alu_idle_after got=0 exp=1"); end
  endtask

  task automatic test_lw_wait;
    obs_t o;
    run_op(mk_bus(4'b1010, 32'h0, 32'h100, 5'd3, 32'h100), 3, 32'hDEADBEEF, 0, o);
    checks++; if (o.reqs !== 3) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=3", o.reqs); end
    checks++; if (o.addr !== 32'h100 || o.wr !== 1'b0) begin errors++; $display("FAIL lw_addr got=%h wr=%b exp=100 wr=0", o.addr, o.wr); end
    checks++; if (o.over_cyc !== 4) begin errors++; $display("FAIL lw_over_cycle got=%0d exp=4", o.over_cyc); end
    checks++; if (o.res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_result got=%h exp=deadbeef", o.res); end
    checks++; if (!o.pend_ok || !o.stable) begin errors++; $display("FAIL lw_pending_stable got=%0d/%0d exp=1/1", o.pend_ok, o.stable); end
  endtask

  task automatic test_lb;
    obs_t o;
    run_op(mk_bus(4'b1001, 32'h0, 32'h103, 5'd4, 32'h200), 1, 32'h80112233, 0, o);
    checks++; if (o.res !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", o.res); end
    checks++; if (o.over_cyc !== 2) begin errors++; $display("FAIL lb_min_latency got=%0d exp=2", o.over_cyc); end
    run_op(mk_bus(4'b1000, 32'h0, 32'h103, 5'd4, 32'h204), 1, 32'h80112233, 0, o);
    checks++; if (o.res !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", o.res); end
    run_op(mk_bus(4'b1001, 32'h0, 32'h101, 5'd4, 32'h208), 2, 32'h80112233, 0, o);
    checks++; if (o.res !== 32'h00000022) begin errors++; $display("FAIL lb_byte1 got=%h exp=00000022", o.res); end
  endtask

  task automatic test_store;
    obs_t o;
    logic [153:0] b;
    b = mk_bus(4'b0100, 32'h000000A5, 32'h202, 5'd0, 32'h300);
    run_op(b, 1, 32'h0, 0, o);
    checks++; if (o.wr !== 1'b1 || o.wstrb !== 4'b0100) begin errors++; $display("FAIL sb_wr_wstrb got=%b/%b exp=1/0100", o.wr, o.wstrb); end
    checks++; if (o.wdata !== 32'hA5A5A5A5 || o.addr !== 32'h200) begin errors++; $display("FAIL sb_wdata_addr got=%h/%h exp=a5a5a5a5/200", o.wdata, o.addr); end
    checks++; if (o.res !== 32'h202) begin errors++; $display("FAIL sb_result got=%h exp=202", o.res); end
    b = mk_bus(4'b0110, 32'h11223344, 32'h206, 5'd0, 32'h304);
    run_op(b, 2, 32'h0, 0, o);
    checks++; if (o.wstrb !== 4'b1111 || o.wdata !== 32'h11223344) begin errors++; $display("FAIL sw_wstrb got=%b/%h exp=1111/11223344", o.wstrb, o.wdata); end
    checks++; if (o.addr !== 32'h204) begin errors++; $display("FAIL sw_unaligned_addr got=%h exp=204", o.addr); end
  endtask

  task automatic test_stall;
    obs_t o;
    run_op(mk_bus(4'b1010, 32'h0, 32'h400, 5'd7, 32'h500), 2, 32'h0BADF00D, 4, o);
    checks++; if (!o.stable) begin errors++; $display("FAIL stall_stable got=0 exp=1"); end
    checks++; if (o.res !== 32'h0BADF00D) begin errors++; $display("FAIL stall_result got=%h exp=0badf00d", o.res); end
    checks++; if (!o.idle_after) begin errors++; $display("FAIL stall_idle_after got=0 exp=1"); end
    run_op(mk_bus(4'b1010, 32'h0, 32'h404, 5'd7, 32'h504), 1, 32'h13572468, 0, o);
    checks++; if (o.reqs !== 1 || o.res !== 32'h13572468) begin errors++; $display("FAIL stall_next_lw reqs=%0d res=%h exp=1/13572468", o.reqs, o.res); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    @(negedge clk);
    mif.EXE_MEM_bus_r = mk_bus(4'b1010, 32'h0, 32'h300, 5'd7, 32'h600);
    mif.MEM_valid = 1'b1; mif.dc_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mif.dc_req !== 1'b1) begin errors++; $display("FAIL rstmid_in_req got=%b exp=1", mif.dc_req); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (mif.dc_req !== 1'b0 || mif.MEM_over !== 1'b0) begin errors++; $display("FAIL rstmid_abandon req=%b over=%b exp=0/0", mif.dc_req, mif.MEM_over); end
    checks++; if (mif.MEM_result !== 32'h0) begin errors++; $display("FAIL rstmid_load_data got=%h exp=0", mif.MEM_result); end
    reset = 1'b0; mif.MEM_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (mif.dc_req !== 1'b0 || mif.MEM_over !== 1'b0) begin errors++; $display("FAIL rstmid_idle req=%b over=%b exp=0/0", mif.dc_req, mif.MEM_over); end
    run_op(mk_bus(4'b1010, 32'h0, 32'h308, 5'd8, 32'h604), 2, 32'h5A5A1234, 0, o);
    checks++; if (o.reqs !== 2 || o.res !== 32'h5A5A1234) begin errors++; $display("FAIL rstmid_reload reqs=%0d res=%h exp=2/5a5a1234", o.reqs, o.res); end
  endtask

  task automatic test_random;
    obs_t o;
    logic [153:0] b;
    logic [3:0]  ctrl;
    logic [31:0] rdata;
    int w, h, exp_over, exp_reqs;
    bit memop;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: ctrl = 4'b0000;
        1: ctrl = {3'b101, 1'($urandom)};
        2: ctrl = {3'b100, 1'($urandom)};
        3: ctrl = 4'b0110;
        default: ctrl = 4'b0100;
      endcase
      b = mk_bus(ctrl, $urandom, $urandom, 5'($urandom), $urandom);
      rdata = $urandom; w = $urandom_range(1, 4); h = $urandom_range(0, 3);
      memop = ctrl[3] | ctrl[2];
      exp_over = memop ? w + 1 : 0;
      exp_reqs = memop ? w : 0;
      run_op(b, w, rdata, h, o);
      checks++;
      if (o.over_cyc !== exp_over || o.reqs !== exp_reqs) begin
        errors++; $display("FAIL rand%0d_timing over=%0d reqs=%0d exp=%0d/%0d", n, o.over_cyc, o.reqs, exp_over, exp_reqs);
      end
      checks++;
      if (o.wb !== {exp_res(b, rdata), b[85:0]}) begin
        errors++; $display("FAIL rand%0d_wb got=%h exp=%h", n, o.wb, {exp_res(b, rdata), b[85:0]});
      end
      checks++;
      if (!o.stable || !o.pend_ok || !o.idle_after) begin
        errors++; $display("FAIL rand%0d_handshake stable=%0d pend=%0d idle=%0d exp=1/1/1", n, o.stable, o.pend_ok, o.idle_after);
      end
      if (memop) begin
        checks++;
        if (o.wr !== ctrl[2] || o.addr !== (b[117:86] & 32'hFFFFFFFC)) begin
          errors++; $display("FAIL rand%0d_req wr=%b addr=%h exp=%b/%h", n, o.wr, o.addr, ctrl[2], b[117:86] & 32'hFFFFFFFC);
        end
      end
      if (ctrl[2]) begin
        checks++;
        if (o.wstrb !== exp_wstrb(b) || o.wdata !== exp_wdata(b)) begin
          errors++; $display("FAIL rand%0d_store got=%b/%h exp=%b/%h", n, o.wstrb, o.wdata, exp_wstrb(b), exp_wdata(b));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_lb();
    test_store();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
